// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main control FSM sequencing fetch/decode/execute/memory/writeback for the multi-cycle core
module multicycle_main_control #(
    parameter logic [3:0] RESET_STATE_ENC = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        EXEC_I    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        ILLEGAL   = 4'd12
    } state_t;

    state_t r_state;
    logic   w_taken;

    assign state_dbg = r_state;
    assign w_taken = (opcode == 4'b1001) ? alu_zero :
                     (opcode == 4'b1010) ? !alu_zero :
                     (opcode == 4'b1011) ? alu_neg :
                     (opcode == 4'b1100) ? (!alu_neg && !alu_zero) : 1'b0;

    // State sequencing; memory states hold until mem_ready, unused encodings fall back to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= state_t'(RESET_STATE_ENC);
        end else begin
            case (r_state)
                FETCH:     r_state <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        4'b0000:                            r_state <= EXEC_R;
                        4'b0001, 4'b0010, 4'b0011, 4'b0100: r_state <= EXEC_I;
                        4'b0111, 4'b1000:                   r_state <= MEM_ADDR;
                        4'b1001, 4'b1010, 4'b1011, 4'b1100: r_state <= BRANCH;
                        4'b1101:                            r_state <= JUMP;
                        default:                            r_state <= ILLEGAL;
                    endcase
                end
                MEM_ADDR:  r_state <= (opcode == 4'b0111) ? MEM_READ : MEM_WRITE;
                MEM_READ:  r_state <= mem_ready ? MEM_WB : MEM_READ;
                MEM_WRITE: r_state <= mem_ready ? FETCH : MEM_WRITE;
                EXEC_R:    r_state <= R_WB;
                EXEC_I:    r_state <= I_WB;
                default:   r_state <= FETCH;
            endcase
        end
    end

    // Control outputs decoded from state so an async reset drops them at once
    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUOp      = 4'b0111;
        illegal_op = 1'b0;
        case (r_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            DECODE:    ALUSrcB = 2'b11;
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 4'b0000;
            end
            R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                ALUOp    = 4'b0000;
            end
            EXEC_I, MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = opcode;
            end
            I_WB: begin
                RegWrite = 1'b1;
                ALUOp    = opcode;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = opcode;
                PCSource = 2'b01;
                PCWrite  = w_taken;
            end
            JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            ILLEGAL:   illegal_op = 1'b1;
            default:   ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: randomized instruction streams checked against a per-instruction step model
module tb_multicycle_main_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       alu_zero, alu_neg, mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp, state_dbg;
    logic [17:0] obs;
    int n_checks = 0;
    int n_fail = 0;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, PCSource, ALUOp, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic branch_taken(input logic [3:0] op, input logic z, input logic n);
        return (op == 4'd9) ? z : (op == 4'd10) ? !z : (op == 4'd11) ? n : (op == 4'd12) ? (!n && !z) : 1'b0;
    endfunction

    // Spec table of control values for a step: order matches obs
    function automatic logic [17:0] exp_ctrl(input int st, input logic [3:0] op, input logic mr,
                                             input logic z, input logic n);
        logic pcw, iord, mrd, mwr, irw, rd, m2r, rw, asa, ill;
        logic [1:0] asb, pcs;
        logic [3:0] aop;
        {pcw, iord, mrd, mwr, irw, rd, m2r, rw, asa, ill} = '0;
        asb = 2'd0;
        pcs = 2'd0;
        aop = 4'b0111;
        case (st)
            0:  begin mrd = 1; asb = 2'd1; pcw = mr; irw = mr; end
            1:  asb = 2'd3;
            2:  begin asa = 1; asb = 2'd2; aop = op; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 4'd0; end
            7:  begin rd = 1; rw = 1; aop = 4'd0; end
            8:  begin asa = 1; asb = 2'd2; aop = op; end
            9:  begin rw = 1; aop = op; end
            10: begin asa = 1; pcs = 2'd1; aop = op; pcw = branch_taken(op, z, n); end
            11: begin pcs = 2'd2; pcw = 1; end
            12: ill = 1;
            default: ;
        endcase
        return {pcw, iord, mrd, mwr, irw, rd, m2r, rw, asa, asb, pcs, aop, ill};
    endfunction

    // Builds the step list of one instruction (f fetch stalls, m memory stalls) and checks each cycle
    task automatic run_instr(input logic [3:0] op, input int f, input int m, input logic z, input logic n);
        int st_q[$];
        bit mr_q[$];
        for (int i = 0; i < f; i++) begin st_q.push_back(0); mr_q.push_back(0); end
        st_q.push_back(0); mr_q.push_back(1);
        st_q.push_back(1); mr_q.push_back($urandom_range(1));
        if (op == 0) begin
            st_q.push_back(6); mr_q.push_back($urandom_range(1));
            st_q.push_back(7); mr_q.push_back($urandom_range(1));
        end else if (op >= 1 && op <= 4) begin
            st_q.push_back(8); mr_q.push_back($urandom_range(1));
            st_q.push_back(9); mr_q.push_back($urandom_range(1));
        end else if (op == 7 || op == 8) begin
            st_q.push_back(2); mr_q.push_back($urandom_range(1));
            for (int i = 0; i < m; i++) begin st_q.push_back(op == 7 ? 3 : 5); mr_q.push_back(0); end
            st_q.push_back(op == 7 ? 3 : 5); mr_q.push_back(1);
            if (op == 7) begin st_q.push_back(4); mr_q.push_back($urandom_range(1)); end
        end else if (op >= 9 && op <= 12) begin
            st_q.push_back(10); mr_q.push_back($urandom_range(1));
        end else if (op == 13) begin
            st_q.push_back(11); mr_q.push_back($urandom_range(1));
        end else begin
            st_q.push_back(12); mr_q.push_back($urandom_range(1));
        end
        opcode = op;
        alu_zero = z;
        alu_neg = n;
        foreach (st_q[i]) begin
            mem_ready = mr_q[i];
            #3;
            check($sformatf("state op%h step%0d", op, i), 32'(state_dbg), 32'(st_q[i]));
            check($sformatf("ctrl op%h st%0d", op, st_q[i]), 32'(obs), 32'(exp_ctrl(st_q[i], op, mr_q[i], z, n)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 4'd0;
        alu_zero = 1'b0;
        alu_neg = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(state_dbg), 32'd0);
        check("reset ctrl", 32'(obs), 32'(exp_ctrl(0, 4'd0, 1'b0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        run_instr(4'b0000, 0, 0, 1'b0, 1'b0);
        run_instr(4'b0111, 1, 2, 1'b0, 1'b0);
        run_instr(4'b1001, 0, 0, 1'b1, 1'b0);
        run_instr(4'b1010, 0, 0, 1'b1, 1'b0);
        run_instr(4'b1100, 0, 0, 1'b0, 1'b0);
        run_instr(4'b1011, 0, 0, 1'b0, 1'b1);
        run_instr(4'b0001, 0, 0, 1'b0, 1'b0);
        run_instr(4'b1000, 0, 3, 1'b0, 1'b0);
        run_instr(4'b1110, 0, 0, 1'b0, 1'b0);
        run_instr(4'b1101, 2, 0, 1'b0, 1'b0);
        // sw stalled in MEM_WRITE, then reset mid-cycle
        opcode = 4'b1000;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #3;
        check("pre-reset MemWrite", 32'(MemWrite), 32'd1);
        check("pre-reset state", 32'(state_dbg), 32'd5);
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("async MemWrite drop", 32'(MemWrite), 32'd0);
        check("async state", 32'(state_dbg), 32'd0);
        check("async fetch ctrl", 32'(obs), 32'(exp_ctrl(0, 4'b1000, 1'b1, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++)
            run_instr(4'($urandom_range(15)), $urandom_range(2), $urandom_range(2),
                      1'($urandom_range(1)), 1'($urandom_range(1)));
        #3;
        check("final state", 32'(state_dbg), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
